// File: rtl/rpc2_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rpc2_ctrl_pkg
// Description : Shared types and constants for the RPC2 controller transfer
//               arbiter: FSM state encoding, transfer direction constants and
//               the default burst-split geometry.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rpc2_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int unsigned DEF_DATA_BYTES  = 4;
    localparam int unsigned DEF_BOUND_BYTES = 1024;
    localparam int unsigned BOUND_BEATS     = DEF_BOUND_BYTES / DEF_DATA_BYTES;

    // Beats that fit between two split boundaries for a given geometry.
    function automatic int unsigned bound_beats(input int unsigned bound_bytes,
                                                input int unsigned data_bytes);
        return bound_bytes / data_bytes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rpc2_ctrl_xfer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rpc2_ctrl_xfer_arbiter_if
// Description : Bundles the write/read request channels, arbitration config,
//               the chunk command channel to the PSRAM sequencer and the busy
//               flag.
//               master : arbiter side (drives req_ready, cmd_*, busy)
//               slave  : requester/sequencer side (drives req_*, cfg_*,
//                        cmd_ready, done)
// Revision    : 1.0 - initial release
// ============================================================================
interface rpc2_ctrl_xfer_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 4
);
    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [LEN_W-1:0]  wr_req_len;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [LEN_W-1:0]  rd_req_len;
    logic              cfg_wr_prio;
    logic [CNT_W-1:0]  cfg_max_consec;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_last;
    logic              done;
    logic              busy;

    modport master (
        input  wr_req_valid, wr_req_addr, wr_req_len,
        input  rd_req_valid, rd_req_addr, rd_req_len,
        input  cfg_wr_prio, cfg_max_consec,
        input  cmd_ready, done,
        output wr_req_ready, rd_req_ready,
        output cmd_valid, cmd_rw, cmd_addr, cmd_len, cmd_last, busy
    );

    modport slave (
        output wr_req_valid, wr_req_addr, wr_req_len,
        output rd_req_valid, rd_req_addr, rd_req_len,
        output cfg_wr_prio, cfg_max_consec,
        output cmd_ready, done,
        input  wr_req_ready, rd_req_ready,
        input  cmd_valid, cmd_rw, cmd_addr, cmd_len, cmd_last, busy
    );

endinterface
`default_nettype wire

// File: rtl/rpc2_ctrl_chunk_calc.sv
`default_nettype none
// ============================================================================
// Module      : rpc2_ctrl_chunk_calc
// Description : Combinational chunk sizing. Given the current byte address and
//               the beats still to transfer, returns the beats-1 of the next
//               chunk so that it never crosses a BOUND_BYTES boundary, and
//               flags when that chunk finishes the request.
// Ports       : i_addr        current byte address (DATA_BYTES aligned)
//               i_remaining   beats left, 1..2^LEN_W
//               o_chunk_len   chunk beats-1
//               o_is_last     chunk covers all remaining beats
// Revision    : 1.0 - initial release
// ============================================================================
module rpc2_ctrl_chunk_calc
    import rpc2_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 8,
    parameter int DATA_BYTES  = 4,
    parameter int BOUND_BYTES = 1024
) (
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [LEN_W:0]    i_remaining,
    output logic      [LEN_W-1:0]  o_chunk_len,
    output logic                   o_is_last
);
    localparam int unsigned      C_BEATS  = bound_beats(BOUND_BYTES, DATA_BYTES);
    localparam int               C_DOFF_W = $clog2(DATA_BYTES);
    localparam int               C_BOFF_W = $clog2(BOUND_BYTES);
    localparam logic [LEN_W:0]   C_ONE    = 1;
    localparam logic [LEN_W:0]   C_BEATS_V = C_BEATS[LEN_W:0];

    logic [LEN_W:0] w_beat_off;
    logic [LEN_W:0] w_to_bound;
    logic [LEN_W:0] w_chunk;
    logic [LEN_W:0] w_chunk_m1;
    logic           w_unused;

    // Beat index of the address within its boundary window.
    generate
        if (C_BOFF_W > C_DOFF_W) begin : g_off
            localparam int C_OW = C_BOFF_W - C_DOFF_W;
            assign w_beat_off = {{(LEN_W + 1 - C_OW){1'b0}}, i_addr[C_BOFF_W-1:C_DOFF_W]};
        end else begin : g_no_off
            assign w_beat_off = '0;
        end
    endgenerate

    assign w_to_bound  = C_BEATS_V - w_beat_off;
    assign o_is_last   = (i_remaining <= w_to_bound);
    assign w_chunk     = o_is_last ? i_remaining : w_to_bound;
    // A chunk holds at most 2^LEN_W beats, so beats-1 always fits LEN_W bits.
    assign w_chunk_m1  = w_chunk - C_ONE;
    assign o_chunk_len = w_chunk_m1[LEN_W-1:0];

    assign w_unused = &{1'b0, i_addr, w_chunk_m1};

endmodule
`default_nettype wire

// File: rtl/rpc2_ctrl_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rpc2_ctrl_xfer_arbiter
// Description : Shares the PSRAM transaction sequencer between the write and
//               read request paths. Grants one request at a time (priority
//               type with a streak limit, or round-robin), splits the granted
//               burst into boundary-safe chunks and issues them one at a time,
//               waiting for the sequencer's done pulse between chunks.
// Ports       : clk      controller clock
//               reset_n  asynchronous active-low reset
//               bus      request/config/command bundle (master modport)
// Revision    : 1.0 - initial release
// ============================================================================
module rpc2_ctrl_xfer_arbiter
    import rpc2_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 8,
    parameter int DATA_BYTES  = DEF_DATA_BYTES,
    parameter int BOUND_BYTES = DEF_BOUND_BYTES,
    parameter int CNT_W       = 4
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    rpc2_ctrl_xfer_arbiter_if.master bus
);
    localparam int             C_DOFF_W = $clog2(DATA_BYTES);
    localparam logic [LEN_W:0] C_ONE    = 1;

    state_t            r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
    logic [LEN_W:0]    r_rem,       w_rem_nxt;
    logic              r_rw,        w_rw_nxt;
    logic [CNT_W-1:0]  r_streak,    w_streak_nxt;
    logic              r_last_type, w_last_type_nxt;
    logic              r_wr_ready,  w_wr_ready_nxt;
    logic              r_rd_ready,  w_rd_ready_nxt;
    logic              r_cmd_valid, w_cmd_valid_nxt;
    logic              r_cmd_rw,    w_cmd_rw_nxt;
    logic [ADDR_W-1:0] r_cmd_addr,  w_cmd_addr_nxt;
    logic [LEN_W-1:0]  r_cmd_len,   w_cmd_len_nxt;
    logic              r_cmd_last,  w_cmd_last_nxt;

    logic [LEN_W-1:0]  w_chunk_len;
    logic              w_is_last;
    logic              w_pick_wr;
    logic              w_both;
    logic [LEN_W:0]    w_cmd_beats;
    logic [ADDR_W-1:0] w_addr_step;

    rpc2_ctrl_chunk_calc #(
        .ADDR_W      (ADDR_W),
        .LEN_W       (LEN_W),
        .DATA_BYTES  (DATA_BYTES),
        .BOUND_BYTES (BOUND_BYTES)
    ) u_chunk_calc (
        .i_addr      (r_addr),
        .i_remaining (r_rem),
        .o_chunk_len (w_chunk_len),
        .o_is_last   (w_is_last)
    );

    // Arbitration decision, only meaningful when at least one request is valid.
    assign w_both = bus.wr_req_valid && bus.rd_req_valid;
    always_comb begin
        w_pick_wr = bus.wr_req_valid;
        if (w_both) begin
            if (bus.cfg_max_consec != '0) begin
                w_pick_wr = (r_streak < bus.cfg_max_consec) ? bus.cfg_wr_prio : !bus.cfg_wr_prio;
            end else begin
                w_pick_wr = (r_last_type == RW_READ);
            end
        end
    end

    assign w_cmd_beats = {1'b0, r_cmd_len} + C_ONE;
    assign w_addr_step = ADDR_W'(w_cmd_beats) << C_DOFF_W;

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_rem_nxt       = r_rem;
        w_rw_nxt        = r_rw;
        w_streak_nxt    = r_streak;
        w_last_type_nxt = r_last_type;
        w_wr_ready_nxt  = 1'b0;
        w_rd_ready_nxt  = 1'b0;
        w_cmd_valid_nxt = r_cmd_valid;
        w_cmd_rw_nxt    = r_cmd_rw;
        w_cmd_addr_nxt  = r_cmd_addr;
        w_cmd_len_nxt   = r_cmd_len;
        w_cmd_last_nxt  = r_cmd_last;

        case (r_state)
            ST_IDLE: begin
                if (bus.wr_req_valid || bus.rd_req_valid) begin
                    w_state_nxt     = ST_ISSUE;
                    w_rw_nxt        = w_pick_wr ? RW_WRITE : RW_READ;
                    w_last_type_nxt = w_rw_nxt;
                    w_addr_nxt      = w_pick_wr ? bus.wr_req_addr : bus.rd_req_addr;
                    w_rem_nxt       = {1'b0, (w_pick_wr ? bus.wr_req_len : bus.rd_req_len)} + C_ONE;
                    w_wr_ready_nxt  = w_pick_wr;
                    w_rd_ready_nxt  = !w_pick_wr;
                    // Streak only grows while the other type is being held off.
                    if (w_both && (w_pick_wr == bus.cfg_wr_prio)) begin
                        if (r_streak != '1) begin
                            w_streak_nxt = r_streak + 1'b1;
                        end
                    end else begin
                        w_streak_nxt = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (!r_cmd_valid) begin
                    // First chunk after a grant: address/remaining were just latched.
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_rw_nxt    = r_rw;
                    w_cmd_addr_nxt  = r_addr;
                    w_cmd_len_nxt   = w_chunk_len;
                    w_cmd_last_nxt  = w_is_last;
                end else if (bus.cmd_ready) begin
                    w_cmd_valid_nxt = 1'b0;
                    w_addr_nxt      = r_addr + w_addr_step;
                    w_rem_nxt       = r_rem - w_cmd_beats;
                    w_state_nxt     = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.done) begin
                    if (r_rem == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        // Present the next chunk on the cycle right after done.
                        w_state_nxt     = ST_ISSUE;
                        w_cmd_valid_nxt = 1'b1;
                        w_cmd_rw_nxt    = r_rw;
                        w_cmd_addr_nxt  = r_addr;
                        w_cmd_len_nxt   = w_chunk_len;
                        w_cmd_last_nxt  = w_is_last;
                    end
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_cmd_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_rem       <= '0;
            r_rw        <= RW_READ;
            r_streak    <= '0;
            r_last_type <= RW_READ;
            r_wr_ready  <= 1'b0;
            r_rd_ready  <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_rw    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_len   <= '0;
            r_cmd_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_rem       <= w_rem_nxt;
            r_rw        <= w_rw_nxt;
            r_streak    <= w_streak_nxt;
            r_last_type <= w_last_type_nxt;
            r_wr_ready  <= w_wr_ready_nxt;
            r_rd_ready  <= w_rd_ready_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd_rw    <= w_cmd_rw_nxt;
            r_cmd_addr  <= w_cmd_addr_nxt;
            r_cmd_len   <= w_cmd_len_nxt;
            r_cmd_last  <= w_cmd_last_nxt;
        end
    end

    assign bus.wr_req_ready = r_wr_ready;
    assign bus.rd_req_ready = r_rd_ready;
    assign bus.cmd_valid    = r_cmd_valid;
    assign bus.cmd_rw       = r_cmd_rw;
    assign bus.cmd_addr     = r_cmd_addr;
    assign bus.cmd_len      = r_cmd_len;
    assign bus.cmd_last     = r_cmd_last;
    assign bus.busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rpc2_ctrl_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rpc2_ctrl_xfer_arbiter
// Description : Directed self-checking bench for rpc2_ctrl_xfer_arbiter.
//               Inputs are driven and outputs sampled 1 ns after the rising
//               edge; expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rpc2_ctrl_xfer_arbiter;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 8;
    localparam int CNT_W  = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    rpc2_ctrl_xfer_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    rpc2_ctrl_xfer_arbiter #(
        .ADDR_W      (ADDR_W),
        .LEN_W       (LEN_W),
        .DATA_BYTES  (4),
        .BOUND_BYTES (1024),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds both requests valid, acts as a zero-wait sequencer (accept at once,
    // done one cycle after accept) and logs grant order, 1 = write.
    task automatic collect(input int n, output logic [7:0] g, output int got);
        logic acc;
        acc = 1'b0;
        g   = '0;
        got = 0;
        bus.cmd_ready    = 1'b1;
        bus.wr_req_valid = 1'b1;
        bus.rd_req_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            bus.done = 1'b0;
            if (acc) begin
                bus.done = 1'b1;
                acc      = 1'b0;
            end
            if (bus.wr_req_ready && got < 8) begin g[got] = 1'b1; got++; end
            if (bus.rd_req_ready && got < 8) begin g[got] = 1'b0; got++; end
            if (got >= n) begin
                bus.wr_req_valid = 1'b0;
                bus.rd_req_valid = 1'b0;
            end
            if (bus.cmd_valid) acc = 1'b1;
            if (got >= n && !bus.busy && !bus.done) break;
        end
        bus.done         = 1'b0;
        bus.wr_req_valid = 1'b0;
        bus.rd_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] g;
        int         got;

        bus.wr_req_valid   = 1'b0;
        bus.wr_req_addr    = '0;
        bus.wr_req_len     = '0;
        bus.rd_req_valid   = 1'b0;
        bus.rd_req_addr    = '0;
        bus.rd_req_len     = '0;
        bus.cfg_wr_prio    = 1'b1;
        bus.cfg_max_consec = 4'd2;
        bus.cmd_ready      = 1'b1;
        bus.done           = 1'b0;

        // Reset state
        tick(3);
        chk("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_wr_ready",  64'(bus.wr_req_ready), 64'd0);
        chk("rst_rd_ready",  64'(bus.rd_req_ready), 64'd0);
        reset_n = 1'b1;
        tick(1);
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // 1: single write, one chunk
        bus.wr_req_addr  = 32'h0;
        bus.wr_req_len   = 8'd7;
        bus.wr_req_valid = 1'b1;
        tick(1);
        chk("t1_wr_ready",  64'(bus.wr_req_ready), 64'd1);
        chk("t1_busy",      64'(bus.busy),         64'd1);
        chk("t1_cmd_early", 64'(bus.cmd_valid),    64'd0);
        bus.wr_req_valid = 1'b0;
        tick(1);
        chk("t1_cmd_valid", 64'(bus.cmd_valid),    64'd1);
        chk("t1_cmd_rw",    64'(bus.cmd_rw),       64'd1);
        chk("t1_cmd_addr",  64'(bus.cmd_addr),     64'h0);
        chk("t1_cmd_len",   64'(bus.cmd_len),      64'd7);
        chk("t1_cmd_last",  64'(bus.cmd_last),     64'd1);
        chk("t1_wr_ready_pulse", 64'(bus.wr_req_ready), 64'd0);
        tick(1);
        chk("t1_accepted",  64'(bus.cmd_valid),    64'd0);
        chk("t1_busy_wait", 64'(bus.busy),         64'd1);
        tick(2);
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0;
        chk("t1_busy_end",  64'(bus.busy),         64'd0);

        // 2: read crossing a 1 KiB boundary -> two chunks
        bus.rd_req_addr  = 32'h3F0;
        bus.rd_req_len   = 8'd15;
        bus.rd_req_valid = 1'b1;
        tick(1);
        chk("t2_rd_ready", 64'(bus.rd_req_ready), 64'd1);
        bus.rd_req_valid = 1'b0;
        tick(1);
        chk("t2_c0_valid", 64'(bus.cmd_valid), 64'd1);
        chk("t2_c0_rw",    64'(bus.cmd_rw),    64'd0);
        chk("t2_c0_addr",  64'(bus.cmd_addr),  64'h3F0);
        chk("t2_c0_len",   64'(bus.cmd_len),   64'd3);
        chk("t2_c0_last",  64'(bus.cmd_last),  64'd0);
        tick(1);
        chk("t2_c0_acc",   64'(bus.cmd_valid), 64'd0);
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0;
        chk("t2_c1_valid", 64'(bus.cmd_valid), 64'd1);
        chk("t2_c1_addr",  64'(bus.cmd_addr),  64'h400);
        chk("t2_c1_len",   64'(bus.cmd_len),   64'd11);
        chk("t2_c1_last",  64'(bus.cmd_last),  64'd1);
        tick(1);
        chk("t2_c1_acc",   64'(bus.cmd_valid), 64'd0);
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0;
        chk("t2_busy_end", 64'(bus.busy), 64'd0);

        // 3: write priority, streak limit 2 -> W,W,R,W,W,R
        bus.wr_req_addr    = 32'h10;
        bus.wr_req_len     = 8'd0;
        bus.rd_req_addr    = 32'h20;
        bus.rd_req_len     = 8'd0;
        bus.cfg_wr_prio    = 1'b1;
        bus.cfg_max_consec = 4'd2;
        collect(6, g, got);
        chk("t3_grant_cnt",   64'(got), 64'd6);
        chk("t3_grant_order", 64'(g),   64'h1B);

        // 4: pure round-robin; last grant was a read -> W,R,W,R
        bus.cfg_max_consec = 4'd0;
        collect(4, g, got);
        chk("t4_grant_cnt",   64'(got), 64'd4);
        chk("t4_grant_order", 64'(g),   64'h05);

        // 5: back-pressure holds the command; done in ISSUE is ignored
        bus.cmd_ready    = 1'b0;
        bus.wr_req_addr  = 32'h100;
        bus.wr_req_len   = 8'd3;
        bus.wr_req_valid = 1'b1;
        tick(1);
        bus.wr_req_valid = 1'b0;
        tick(1);
        chk("t5_cmd_valid", 64'(bus.cmd_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            bus.done = (i == 2);
            tick(1);
            chk("t5_hold_valid", 64'(bus.cmd_valid), 64'd1);
            chk("t5_hold_addr",  64'(bus.cmd_addr),  64'h100);
            chk("t5_hold_len",   64'(bus.cmd_len),   64'd3);
        end
        bus.done = 1'b0;
        chk("t5_busy_hold", 64'(bus.busy), 64'd1);
        bus.cmd_ready = 1'b1;
        tick(1);
        chk("t5_accepted", 64'(bus.cmd_valid), 64'd0);
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0;
        chk("t5_busy_end", 64'(bus.busy), 64'd0);

        // 6: asynchronous reset while waiting for done
        bus.wr_req_addr  = 32'h200;
        bus.wr_req_len   = 8'd3;
        bus.wr_req_valid = 1'b1;
        tick(1);
        bus.wr_req_valid = 1'b0;
        tick(2);
        chk("t6_busy_wait", 64'(bus.busy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy",  64'(bus.busy),         64'd0);
        chk("t6_rst_addr",  64'(bus.cmd_addr),     64'h0);
        chk("t6_rst_len",   64'(bus.cmd_len),      64'd0);
        chk("t6_rst_rw",    64'(bus.cmd_rw),       64'd0);
        chk("t6_rst_last",  64'(bus.cmd_last),     64'd0);
        chk("t6_rst_valid", 64'(bus.cmd_valid),    64'd0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0;
        tick(4);
        chk("t6_no_cmd",  64'(bus.cmd_valid), 64'd0);
        chk("t6_no_busy", 64'(bus.busy),      64'd0);
        // last_type is read after reset, so round-robin grants the write first
        bus.cfg_max_consec = 4'd0;
        collect(1, g, got);
        chk("t6_grant_cnt",   64'(got),  64'd1);
        chk("t6_first_grant", 64'(g[0]), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
